// File: rtl/cim_tile_pkg.sv
// Shared types and width helpers for the CIM tile front end.
package cim_tile_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    COLLECT = 2'd2
  } state_t;

  function automatic int num_addr(int xbar, int dsz, int bus);
    return xbar / (bus / dsz);
  endfunction

  function automatic int col_width(int xbar, int dsz);
    return dsz + $clog2(xbar);
  endfunction

  function automatic int obuf_width(int xbar, int dsz);
    return 2 * dsz + $clog2(xbar);
  endfunction

endpackage

// File: rtl/cim_obuf_acc.sv
// Per-column output buffer: shift-accumulate write port, registered read port.
// A read and an accumulate to the same column return the pre-update value.
module cim_obuf_acc
  import cim_tile_pkg::*;
#(
  parameter int XBAR_SIZE = 512,
  parameter int DATA_SIZE = 8,
  localparam int CW = $clog2(XBAR_SIZE),
  localparam int PW = $clog2(DATA_SIZE),
  localparam int COL_W = col_width(XBAR_SIZE, DATA_SIZE),
  localparam int OBUF_W = obuf_width(XBAR_SIZE, DATA_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_en,
  input  logic              acc_first,
  input  logic [CW-1:0]     acc_addr,
  input  logic [PW-1:0]     acc_shift,
  input  logic [COL_W-1:0]  acc_data,
  input  logic [CW-1:0]     rd_addr,
  output logic [OBUF_W-1:0] rd_data
);

  logic [OBUF_W-1:0] mem [XBAR_SIZE];
  logic [OBUF_W-1:0] ext;

  assign ext = OBUF_W'(acc_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < XBAR_SIZE; i++)
        mem[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (acc_en)
        mem[acc_addr] <= acc_first ? ext
                       : mem[acc_addr] + (ext << acc_shift);
    end
  end

endmodule

// File: rtl/cim_tile_frontend.sv
// CIM tile front end: input vector assembly, bit-serial crossbar passes.
// Define CIM_TILE_OVERRUN_EN to add the sticky o_overrun flag.
module cim_tile_frontend
  import cim_tile_pkg::*;
#(
  parameter int XBAR_SIZE = 512,
  parameter int DATA_SIZE = 8,
  parameter int BUS_WIDTH = 16,
  localparam int NUM_ADDR = num_addr(XBAR_SIZE, DATA_SIZE, BUS_WIDTH),
  localparam int COL_DATA_SIZE = col_width(XBAR_SIZE, DATA_SIZE),
  localparam int OBUF_DATA_SIZE = obuf_width(XBAR_SIZE, DATA_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_we,
  input  logic [$clog2(NUM_ADDR)-1:0]  i_wr_addr,
  input  logic [BUS_WIDTH-1:0]         i_wr_data,
  output logic                         o_ready,
  output logic [XBAR_SIZE-1:0]         o_xbar_in,
  output logic                         o_xbar_start,
  input  logic                         i_xbar_valid,
  input  logic [COL_DATA_SIZE-1:0]     i_xbar_data,
`ifdef CIM_TILE_OVERRUN_EN
  output logic                         o_overrun,
`endif
  input  logic [$clog2(XBAR_SIZE)-1:0] i_rd_addr,
  output logic [OBUF_DATA_SIZE-1:0]    o_rd_data
);

  localparam int AW = $clog2(NUM_ADDR);
  localparam int CW = $clog2(XBAR_SIZE);
  localparam int PW = $clog2(DATA_SIZE);

  state_t state, state_n;
  logic [CW-1:0] col, col_n;
  logic [PW-1:0] plane, plane_n;
  logic acc_en;

  logic [XBAR_SIZE-1:0][DATA_SIZE-1:0] vec, vec_n;
  logic [NUM_ADDR-1:0][BUS_WIDTH-1:0] words;
  logic [XBAR_SIZE-1:0] bits;

  assign o_ready = (state == IDLE);

  // Word view and row view share one layout: row r sits at bits r*DATA_SIZE.
  always_comb begin
    words = vec;
    if (i_we && state == IDLE)
      words[i_wr_addr] = i_wr_data;
    vec_n = words;
  end

  // Plane is sliced from the next-state vector so the final word is included.
  always_comb begin
    bits = '0;
    for (int r = 0; r < XBAR_SIZE; r++)
      bits[r] = vec_n[r][plane_n];
  end

  always_comb begin
    state_n = state;
    col_n   = col;
    plane_n = plane;
    acc_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_we && i_wr_addr == AW'(NUM_ADDR - 1))
          state_n = START;
      end
      START: state_n = COLLECT;
      COLLECT: begin
        if (i_xbar_valid) begin
          acc_en = 1'b1;
          col_n  = col + 1'b1;
          if (col == CW'(XBAR_SIZE - 1)) begin
            col_n = '0;
            if (plane == PW'(DATA_SIZE - 1)) begin
              plane_n = '0;
              state_n = IDLE;
            end else begin
              plane_n = plane + 1'b1;
              state_n = START;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      plane        <= '0;
      vec          <= '0;
      o_xbar_in    <= '0;
      o_xbar_start <= 1'b0;
    end else begin
      state        <= state_n;
      col          <= col_n;
      plane        <= plane_n;
      vec          <= vec_n;
      o_xbar_start <= (state_n == START);
      if (state_n == START)
        o_xbar_in <= bits;
    end
  end

`ifdef CIM_TILE_OVERRUN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_overrun <= 1'b0;
    else if ((i_we && state != IDLE) || (i_xbar_valid && state != COLLECT))
      o_overrun <= 1'b1;
  end
`endif

  cim_obuf_acc #(
    .XBAR_SIZE (XBAR_SIZE),
    .DATA_SIZE (DATA_SIZE)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .acc_en    (acc_en),
    .acc_first (plane == '0),
    .acc_addr  (col),
    .acc_shift (plane),
    .acc_data  (i_xbar_data),
    .rd_addr   (i_rd_addr),
    .rd_data   (o_rd_data)
  );

endmodule

// File: tb/tb_cim_tile_frontend.sv
// Bench for cim_tile_frontend: crossbar macro model plus matrix-vector reference.
// Optional overrun checks compile in with CIM_TILE_OVERRUN_EN.
module tb_cim_tile_frontend;

  localparam int XS  = 8;
  localparam int DS  = 2;
  localparam int BW  = 4;
  localparam int EPW = BW / DS;
  localparam int NA  = XS / EPW;
  localparam int CDW = DS + $clog2(XS);
  localparam int OW  = 2 * DS + $clog2(XS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           we;
  logic [1:0]     wr_addr;
  logic [BW-1:0]  wr_data;
  logic           ready;
  logic [XS-1:0]  xin;
  logic           xstart;
  logic           xv;
  logic [CDW-1:0] xd;
  logic [2:0]     rd_addr;
  logic [OW-1:0]  rd_data;
`ifdef CIM_TILE_OVERRUN_EN
  logic           overrun;
`endif

  cim_tile_frontend #(
    .XBAR_SIZE (XS),
    .DATA_SIZE (DS),
    .BUS_WIDTH (BW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_we         (we),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_ready      (ready),
    .o_xbar_in    (xin),
    .o_xbar_start (xstart),
    .i_xbar_valid (xv),
    .i_xbar_data  (xd),
`ifdef CIM_TILE_OVERRUN_EN
    .o_overrun    (overrun),
`endif
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0] vword [NA];
  int  w [XS][XS];
  bit  gap_mode;
  bit  dot_mode;
  int  starts;
  logic [XS-1:0] plane_log [$];
  bit  active;
  int  mc;
  int  ph;

  // Macro model: column c returns c+1, or the dot product of the plane with weight column c.
  function automatic logic [CDW-1:0] col_dot(int c);
    int s = 0;
    for (int r = 0; r < XS; r++)
      if (xin[r]) s += w[r][c];
    return CDW'(s);
  endfunction

  initial begin
    xv = 1'b0;
    xd = '0;
    active = 1'b0;
    starts = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        active = 1'b0;
        xv = 1'b0;
      end else if (xstart) begin
        starts++;
        plane_log.push_back(xin);
        active = 1'b1;
        mc = 0;
        ph = 0;
        xv = 1'b0;
      end else if (active) begin
        if (mc == XS) begin
          active = 1'b0;
          xv = 1'b0;
        end else if (gap_mode && ph != 2) begin
          xv = 1'b0;
          ph++;
        end else begin
          xv = 1'b1;
          xd = dot_mode ? col_dot(mc) : CDW'(mc + 1);
          mc++;
          ph = 0;
        end
      end else begin
        xv = 1'b0;
      end
    end
  end

  // Reference: full-precision element x[r], then y[c] = sum_r x[r]*w[r][c].
  function automatic int model_x(int r);
    logic [BW-1:0] word;
    word = vword[r / EPW];
    return int'((word >> ((r % EPW) * DS)) & ((1 << DS) - 1));
  endfunction

  function automatic int model_col(int c);
    int s = 0;
    if (dot_mode) begin
      for (int r = 0; r < XS; r++)
        s += model_x(r) * w[r][c];
    end else begin
      s = (c + 1) * ((1 << DS) - 1);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_word(input int a, input logic [BW-1:0] d);
    we = 1'b1;
    wr_addr = 2'(a);
    wr_data = d;
    tick();
    we = 1'b0;
  endtask

  task automatic load_vector();
    for (int a = 0; a < NA - 1; a++)
      write_word(a, vword[a]);
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_before_last: got %b expected 1", ready);
    end
    write_word(NA - 1, vword[NA - 1]);
    n_tests++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_drop: got %b expected 0", ready);
    end
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    while (ready !== 1'b1 && busy < 2000) begin
      tick();
      busy++;
    end
  endtask

  task automatic randomize_inputs();
    for (int a = 0; a < NA; a++)
      vword[a] = BW'($urandom);
    for (int r = 0; r < XS; r++)
      for (int c = 0; c < XS; c++)
        w[r][c] = int'($urandom_range(0, (1 << DS) - 1));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", ready);
    end
    n_tests++;
    if (xstart !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start: got %b expected 0", xstart);
    end
    n_tests++;
    if (xin !== '0) begin
      n_fail++;
      $display("FAIL reset_xbar_in: got %h expected 00", xin);
    end
    n_tests++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %0d expected 0", rd_data);
    end
`ifdef CIM_TILE_OVERRUN_EN
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overrun: got %b expected 0", overrun);
    end
`endif
    for (int c = 0; c < XS; c++) begin
      rd_addr = 3'(c);
      tick();
      n_tests++;
      if (rd_data !== '0) begin
        n_fail++;
        $display("FAIL reset_col%0d: got %0d expected 0", c, rd_data);
      end
    end
  endtask

  task automatic test_basic(input bit gaps);
    int busy;
    int s0;
    int q0;
    int exp_busy;
    for (int a = 0; a < NA; a++)
      vword[a] = 4'hE;
    dot_mode = 1'b0;
    gap_mode = gaps;
    s0 = starts;
    q0 = plane_log.size();
    exp_busy = gaps ? DS * (1 + 3 * XS) : DS * (XS + 1);
    load_vector();
    wait_idle(busy);
    n_tests++;
    if (busy !== exp_busy) begin
      n_fail++;
      $display("FAIL busy_gap%0d: got %0d cycles expected %0d", gaps, busy, exp_busy);
    end
    n_tests++;
    if (starts - s0 !== DS) begin
      n_fail++;
      $display("FAIL start_count: got %0d expected %0d", starts - s0, DS);
    end
    n_tests++;
    if (plane_log.size() - q0 !== 2) begin
      n_fail++;
      $display("FAIL plane_count: got %0d expected 2", plane_log.size() - q0);
    end else begin
      n_tests++;
      if (plane_log[q0] !== 8'hAA) begin
        n_fail++;
        $display("FAIL plane0: got %h expected aa", plane_log[q0]);
      end
      n_tests++;
      if (plane_log[q0 + 1] !== 8'hFF) begin
        n_fail++;
        $display("FAIL plane1: got %h expected ff", plane_log[q0 + 1]);
      end
    end
    for (int c = 0; c < XS; c++) begin
      rd_addr = 3'(c);
      tick();
      n_tests++;
      if (rd_data !== OW'(model_col(c))) begin
        n_fail++;
        $display("FAIL basic_gap%0d_col%0d: got %0d expected %0d",
                 gaps, c, rd_data, model_col(c));
      end
    end
  endtask

  task automatic test_random_mvm();
    int busy;
    int exp_busy;
    for (int it = 0; it < 4; it++) begin
      randomize_inputs();
      dot_mode = 1'b1;
      gap_mode = bit'($urandom_range(0, 1));
      exp_busy = gap_mode ? DS * (1 + 3 * XS) : DS * (XS + 1);
      load_vector();
      wait_idle(busy);
      n_tests++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL mvm%0d_busy: got %0d expected %0d", it, busy, exp_busy);
      end
      for (int c = 0; c < XS; c++) begin
        rd_addr = 3'(c);
        tick();
        n_tests++;
        if (rd_data !== OW'(model_col(c))) begin
          n_fail++;
          $display("FAIL mvm%0d_col%0d: got %0d expected %0d",
                   it, c, rd_data, model_col(c));
        end
      end
    end
  endtask

  task automatic test_partial();
    int s0;
    s0 = starts;
    for (int a = 0; a < NA - 1; a++)
      write_word(a, BW'($urandom));
    for (int k = 0; k < 50; k++) begin
      n_tests++;
      if (ready !== 1'b1 || xstart !== 1'b0) begin
        n_fail++;
        $display("FAIL partial_idle_%0d: ready %b start %b expected 1 0",
                 k, ready, xstart);
      end
      tick();
    end
    n_tests++;
    if (starts !== s0) begin
      n_fail++;
      $display("FAIL partial_starts: got %0d expected %0d", starts - s0, 0);
    end
  endtask

  task automatic test_we_busy();
    int busy;
    randomize_inputs();
    dot_mode = 1'b1;
    gap_mode = 1'b0;
    load_vector();
    tick();
    we = 1'b1;
    wr_addr = 2'(NA - 1);
    wr_data = ~vword[NA - 1];
    tick();
    wr_addr = 2'd0;
    wr_data = ~vword[0];
    tick();
    we = 1'b0;
    wait_idle(busy);
    n_tests++;
    if (busy + 3 !== DS * (XS + 1)) begin
      n_fail++;
      $display("FAIL we_busy_time: got %0d expected %0d", busy + 3, DS * (XS + 1));
    end
`ifdef CIM_TILE_OVERRUN_EN
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL we_busy_retrigger_%0d: ready %b expected 1", k, ready);
      end
    end
    for (int c = 0; c < XS; c++) begin
      rd_addr = 3'(c);
      tick();
      n_tests++;
      if (rd_data !== OW'(model_col(c))) begin
        n_fail++;
        $display("FAIL we_busy_col%0d: got %0d expected %0d",
                 c, rd_data, model_col(c));
      end
    end
`ifdef CIM_TILE_OVERRUN_EN
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
`endif
  endtask

  task automatic test_reset_mid_pass();
    int seen;
    int k;
    int busy;
    for (int a = 0; a < NA; a++)
      vword[a] = 4'hE;
    dot_mode = 1'b0;
    gap_mode = 1'b0;
    load_vector();
    seen = 0;
    k = 0;
    while (seen < 2 && k < 200) begin
      if (xstart === 1'b1) seen++;
      if (seen < 2) tick();
      k++;
    end
    n_tests++;
    if (seen !== 2) begin
      n_fail++;
      $display("FAIL mid_second_pass: saw %0d starts expected 2", seen);
    end
    repeat (5) tick();
    rst = 1'b1;
    #1;
    n_tests++;
    if (ready !== 1'b1 || xstart !== 1'b0 || xin !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_state: ready %b start %b xin %h expected 1 0 00",
               ready, xstart, xin);
    end
    tick();
    tick();
    rst = 1'b0;
`ifdef CIM_TILE_OVERRUN_EN
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_overrun: got %b expected 0", overrun);
    end
`endif
    for (int c = 0; c < XS; c++) begin
      rd_addr = 3'(c);
      tick();
      n_tests++;
      if (rd_data !== '0) begin
        n_fail++;
        $display("FAIL mid_reset_col%0d: got %0d expected 0", c, rd_data);
      end
    end
    randomize_inputs();
    dot_mode = 1'b1;
    load_vector();
    wait_idle(busy);
    n_tests++;
    if (busy !== DS * (XS + 1)) begin
      n_fail++;
      $display("FAIL after_reset_busy: got %0d expected %0d", busy, DS * (XS + 1));
    end
    for (int c = 0; c < XS; c++) begin
      rd_addr = 3'(c);
      tick();
      n_tests++;
      if (rd_data !== OW'(model_col(c))) begin
        n_fail++;
        $display("FAIL after_reset_col%0d: got %0d expected %0d",
                 c, rd_data, model_col(c));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    we = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    gap_mode = 1'b0;
    dot_mode = 1'b0;
    test_reset();
    test_basic(1'b0);
    test_basic(1'b1);
    test_random_mvm();
    test_partial();
    test_we_busy();
    test_reset_mid_pass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
